// File: rtl/scfifo_pkg.sv
// Shared sizing helpers and flag compares for the scfifo family.
package scfifo_pkg;

    localparam int unsigned SCFIFO_LOG_DEPTH = 5;

    // Occupancy needs one extra bit so a completely full FIFO is representable.
    typedef logic [SCFIFO_LOG_DEPTH:0] occ_t;

    function automatic int unsigned fifo_depth(input int unsigned log_depth);
        return 32'd1 << log_depth;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned log_depth);
        return log_depth + 32'd1;
    endfunction

    function automatic logic at_or_above(input int unsigned occ, input int unsigned thresh);
        return occ >= thresh;
    endfunction

    function automatic logic below(input int unsigned occ, input int unsigned thresh);
        return occ < thresh;
    endfunction

endpackage

// File: rtl/scfifo_ram.sv
// Simple dual-port RAM, one write and one registered read port; read output clears on rst.
// Latency: read data one cycle after rd_en; a read of the address being written returns the old word.
module scfifo_ram
    import scfifo_pkg::*;
#(
    parameter int unsigned WIDTH  = 20,
    parameter int unsigned ADDR_W = 5,
    parameter string       FAMILY = "Other"
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_dat,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_dat
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_W);

    generate
        if (FAMILY == "Other") begin : g_generic
            logic [WIDTH-1:0] mem [DEPTH];

            always_ff @(posedge clock) begin
                if (wr_en) mem[wr_addr] <= wr_dat;
            end

            always_ff @(posedge clock) begin
                if (rst)        rd_dat <= '0;
                else if (rd_en) rd_dat <= mem[rd_addr];
            end
        end else begin : g_block
            // The FIFO never reads a word in the cycle it is written, so skip bypass logic.
            (* ramstyle = "no_rw_check" *) logic [WIDTH-1:0] mem [DEPTH];

            always_ff @(posedge clock) begin
                if (wr_en) mem[wr_addr] <= wr_dat;
            end

            always_ff @(posedge clock) begin
                if (rst)        rd_dat <= '0;
                else if (rd_en) rd_dat <= mem[rd_addr];
            end
        end
    endgenerate

endmodule

// File: rtl/scfifo_prog.sv
// Single-clock FIFO holding 2^LOG_DEPTH words with runtime almost thresholds and sticky error flags.
// Show-ahead: written word visible one cycle later; writes dropped when full, reads ignored when empty.
module scfifo_prog
    import scfifo_pkg::*;
#(
    parameter int unsigned WIDTH              = 20,
    parameter int unsigned LOG_DEPTH          = 5,
    parameter bit          SHOW_AHEAD         = 1'b1,
    parameter bit          OVERFLOW_CHECKING  = 1'b1,
    parameter bit          UNDERFLOW_CHECKING = 1'b1,
    parameter string       FAMILY             = "Other"
) (
    input  logic               clock,
    input  logic               sclr,
    input  logic [WIDTH-1:0]   data,
    input  logic               wrreq,
    input  logic               rdreq,
    input  logic [LOG_DEPTH:0] af_thresh,
    input  logic [LOG_DEPTH:0] ae_thresh,
    input  logic               err_clr,
    output logic [WIDTH-1:0]   q,
    output logic [LOG_DEPTH:0] usedw,
    output logic               empty,
    output logic               full,
    output logic               almost_empty,
    output logic               almost_full,
    output logic               overflow,
    output logic               underflow
);

    localparam int unsigned DEPTH = fifo_depth(LOG_DEPTH);
    localparam int unsigned CW    = cnt_width(LOG_DEPTH);

    logic [LOG_DEPTH-1:0] wr_ptr;
    logic [LOG_DEPTH-1:0] rd_ptr;
    logic [LOG_DEPTH-1:0] head_ptr;
    logic [CW-1:0]        usedw_nxt;
    logic                 wr_acc;
    logic                 rd_acc;
    logic                 ram_rd_en;
    logic [LOG_DEPTH-1:0] ram_rd_addr;
    logic [WIDTH-1:0]     ram_q;

    assign wr_acc    = ~sclr & wrreq & ~(full & OVERFLOW_CHECKING);
    assign rd_acc    = ~sclr & rdreq & ~(empty & UNDERFLOW_CHECKING);
    assign usedw_nxt = usedw + CW'(wr_acc) - CW'(rd_acc);
    // Pointer to the word that will be at the head after this edge.
    assign head_ptr  = rd_ptr + LOG_DEPTH'(rd_acc);

    always_ff @(posedge clock) begin
        if (sclr) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            usedw        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= below(32'd0, 32'(ae_thresh));
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + LOG_DEPTH'(1);
            rd_ptr       <= head_ptr;
            usedw        <= usedw_nxt;
            empty        <= (usedw_nxt == '0);
            full         <= (usedw_nxt == CW'(DEPTH));
            almost_full  <= at_or_above(32'(usedw_nxt), 32'(af_thresh));
            almost_empty <= below(32'(usedw_nxt), 32'(ae_thresh));
            overflow     <= (wrreq & full) | (overflow & ~err_clr);
            underflow    <= (rdreq & empty) | (underflow & ~err_clr);
        end
    end

    scfifo_ram #(
        .WIDTH  (WIDTH),
        .ADDR_W (LOG_DEPTH),
        .FAMILY (FAMILY)
    ) u_ram (
        .clock   (clock),
        .rst     (sclr),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_dat  (data),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .rd_dat  (ram_q)
    );

    generate
        if (SHOW_AHEAD) begin : g_show_ahead
            logic             byp_sel;
            logic [WIDTH-1:0] byp_dat;

            // The RAM cannot return a word written on the same edge, so the new
            // head is captured straight from data when it lands in that slot.
            always_ff @(posedge clock) begin
                if (sclr) begin
                    byp_sel <= 1'b0;
                    byp_dat <= '0;
                end else if (wr_acc && (wr_ptr == head_ptr)) begin
                    byp_sel <= 1'b1;
                    byp_dat <= data;
                end else if (rd_acc) begin
                    byp_sel <= 1'b0;
                end
            end

            assign ram_rd_en   = 1'b1;
            assign ram_rd_addr = head_ptr;
            assign q           = byp_sel ? byp_dat : ram_q;
        end else begin : g_normal
            assign ram_rd_en   = rd_acc;
            assign ram_rd_addr = rd_ptr;
            assign q           = ram_q;
        end
    endgenerate

endmodule

// File: tb/tb_scfifo_prog.sv
// Randomized scoreboard bench: a show-ahead and a normal-mode FIFO share one stimulus stream.
module tb_scfifo_prog;

    localparam int DEPTH = 32;

    typedef struct {
        int          usedw;
        bit          empty;
        bit          full;
        bit          af;
        bit          ae;
        bit          ovf;
        bit          unf;
        bit          q0;
        logic [19:0] nq;
    } status_t;

    logic        clock;
    logic        sclr;
    logic [19:0] data;
    logic        wrreq;
    logic        rdreq;
    logic [5:0]  af_thresh;
    logic [5:0]  ae_thresh;
    logic        err_clr;

    logic [19:0] q,       n_q;
    logic [5:0]  usedw,   n_usedw;
    logic        empty,   n_empty;
    logic        full,    n_full;
    logic        ae,      n_ae;
    logic        af,      n_af;
    logic        ovf,     n_ovf;
    logic        unf,     n_unf;

    scfifo_prog #(.SHOW_AHEAD(1'b1)) dut (
        .clock(clock), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .err_clr(err_clr),
        .q(q), .usedw(usedw), .empty(empty), .full(full),
        .almost_empty(ae), .almost_full(af), .overflow(ovf), .underflow(unf)
    );

    scfifo_prog #(.SHOW_AHEAD(1'b0)) dut_n (
        .clock(clock), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .err_clr(err_clr),
        .q(n_q), .usedw(n_usedw), .empty(n_empty), .full(n_full),
        .almost_empty(n_ae), .almost_full(n_af), .overflow(n_ovf), .underflow(n_unf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: FIFO contents, sticky flags, normal-mode output word.
    logic [19:0] m_q[$];
    logic [19:0] sb_q[$];
    status_t     st_q[$];
    bit          m_ovf = 1'b0;
    bit          m_unf = 1'b0;
    logic [19:0] m_nq  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        chk(name, 32'(act), 32'(exp));
    endtask

    task automatic model_edge(input bit wr, input bit rd, input logic [19:0] d,
                              input bit clr, input bit rst);
        status_t s;
        bit      was_full;
        bit      was_empty;
        if (rst) begin
            m_q.delete();
            sb_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_nq  = '0;
            s.q0  = 1'b1;
        end else begin
            was_full  = (m_q.size() == DEPTH);
            was_empty = (m_q.size() == 0);
            if (wr && was_full) m_ovf = 1'b1;
            else if (clr)       m_ovf = 1'b0;
            if (rd && was_empty) m_unf = 1'b1;
            else if (clr)        m_unf = 1'b0;
            if (rd && !was_empty) m_nq = m_q.pop_front();
            if (wr && !was_full) begin
                m_q.push_back(d);
                sb_q.push_back(d);
            end
            s.q0 = 1'b0;
        end
        s.usedw = m_q.size();
        s.empty = (m_q.size() == 0);
        s.full  = (m_q.size() == DEPTH);
        s.af    = rst ? 1'b0 : (m_q.size() >= int'(af_thresh));
        s.ae    = (m_q.size() < int'(ae_thresh));
        s.ovf   = m_ovf;
        s.unf   = m_unf;
        s.nq    = m_nq;
        st_q.push_back(s);
    endtask

    task automatic step(input bit wr, input bit rd, input logic [19:0] d,
                        input bit clr, input bit rst);
        wrreq   = wr;
        rdreq   = rd;
        data    = d;
        err_clr = clr;
        sclr    = rst;
        @(posedge clock);
        model_edge(wr, rd, d, clr, rst);
        #1;
    endtask

    always @(negedge clock) begin : monitor
        status_t s;
        if (st_q.size() > 0) begin
            s = st_q.pop_front();
            chk ("usedw",     32'(usedw), s.usedw);
            chkb("empty",     empty, s.empty);
            chkb("full",      full,  s.full);
            chkb("almost_full",  af, s.af);
            chkb("almost_empty", ae, s.ae);
            chkb("overflow",  ovf, s.ovf);
            chkb("underflow", unf, s.unf);
            chk ("n_usedw",   32'(n_usedw), s.usedw);
            chkb("n_empty",   n_empty, s.empty);
            chkb("n_full",    n_full, s.full);
            chkb("n_almost_full",  n_af, s.af);
            chkb("n_almost_empty", n_ae, s.ae);
            chkb("n_overflow",  n_ovf, s.ovf);
            chkb("n_underflow", n_unf, s.unf);
            chk ("n_q",       32'(n_q), 32'(s.nq));
            if (s.q0) chk("q_after_sclr", 32'(q), 32'd0);
            // Show-ahead: any non-empty cycle must present the oldest word.
            if (!empty) begin
                if (sb_q.size() == 0) begin
                    chk("q_head_exists", 32'd0, 32'd1);
                end else begin
                    chk("q_head", 32'(q), 32'(sb_q[0]));
                    if (rdreq) void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks done", n_chk);
        $fatal(1);
    end

    initial begin : stim
        int pw;
        af_thresh = 6'd30;
        ae_thresh = 6'd2;

        repeat (10) step(1'b1, 1'b1, 20'h12345, 1'b0, 1'b1);

        // Fill to capacity, then a dropped write.
        for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 20'(i), 1'b0, 1'b0);
        step(1'b1, 1'b0, 20'd32, 1'b0, 1'b0);
        // Full with write+read: read proceeds, write rejected.
        step(1'b1, 1'b1, 20'd99, 1'b0, 1'b0);
        step(1'b1, 1'b0, 20'd100, 1'b0, 1'b0);

        // Drain back-to-back, then underflow; set beats clear, then clear.
        for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 20'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 20'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 20'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 20'd0, 1'b1, 1'b0);

        // Write-through into empty, then sustained read+write at occupancy 1.
        step(1'b1, 1'b0, 20'hABCDE, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 20'(20'h50 + i), 1'b0, 1'b0);
        step(1'b0, 1'b1, 20'd0, 1'b0, 1'b0);
        // Empty with write+read: write proceeds, read rejected.
        step(1'b1, 1'b1, 20'h777, 1'b0, 1'b0);
        step(1'b0, 1'b1, 20'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 20'd0, 1'b1, 1'b0);

        // Normal-mode hold behaviour between reads.
        step(1'b1, 1'b0, 20'd5, 1'b0, 1'b0);
        step(1'b1, 1'b0, 20'd6, 1'b0, 1'b0);
        step(1'b1, 1'b0, 20'd7, 1'b0, 1'b0);
        step(1'b0, 1'b1, 20'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 20'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 20'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 20'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 20'd0, 1'b0, 1'b0);

        // Threshold extremes.
        af_thresh = 6'd0;
        ae_thresh = 6'd0;
        repeat (2) step(1'b0, 1'b0, 20'd0, 1'b0, 1'b0);
        af_thresh = 6'd1;
        ae_thresh = 6'd33;
        step(1'b1, 1'b0, 20'd9, 1'b0, 1'b0);
        step(1'b0, 1'b0, 20'd0, 1'b0, 1'b0);
        af_thresh = 6'd30;
        ae_thresh = 6'd2;

        // Mid-stream flush at occupancy 17 with a write in the flush cycle.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 20'(20'h100 + i), 1'b0, 1'b0);
        step(1'b1, 1'b1, 20'hFFFFF, 1'b0, 1'b1);
        step(1'b0, 1'b0, 20'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 20'h2468A, 1'b0, 1'b0);

        // Random traffic in write-heavy, balanced and read-heavy bursts.
        for (int blk = 0; blk < 12; blk++) begin
            case (blk % 3)
                0:       pw = 75;
                1:       pw = 50;
                default: pw = 25;
            endcase
            if (blk % 4 == 3) begin
                af_thresh = 6'($urandom_range(0, 32));
                ae_thresh = 6'($urandom_range(0, 33));
            end else begin
                af_thresh = 6'd30;
                ae_thresh = 6'd2;
            end
            for (int i = 0; i < 250; i++)
                step($urandom_range(0, 99) < pw, $urandom_range(0, 99) >= pw,
                     20'($urandom), $urandom_range(0, 31) == 0, 1'b0);
        end

        step(1'b0, 1'b0, 20'd0, 1'b0, 1'b0);
        @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
